// File: rtl/uart_tx_capture.sv
// rtl/uart_tx_capture.sv - 8N1 UART receiver with show-ahead byte FIFO and framing/overrun flags
module uart_tx_capture #(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                             clk12,
  input  logic                             rst_n,
  input  logic                             rx,
  output logic [7:0]                       out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             frame_err,
  output logic                             overrun,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
  output logic                             busy
);

  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [15:0] C_BIT_RELOAD  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] C_HALF_RELOAD = 16'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  logic          r_rx_meta;
  logic          r_rx_s;
  state_t        r_state;
  state_t        w_next;
  logic [15:0]   r_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;

  logic          w_cnt_zero;
  logic          w_push;
  logic          w_full;
  logic          w_pop;
  logic          w_accept;

  assign w_cnt_zero = (r_cnt == 16'd0);

  // Two-flop synchronizer; idles high so reset never looks like a start edge
  always_ff @(posedge clk12 or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  // FSM state register
  always_ff @(posedge clk12 or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode; every sample is taken when the bit counter hits zero
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (!r_rx_s) w_next = S_START;
      S_START: if (w_cnt_zero) w_next = r_rx_s ? S_IDLE : S_DATA;
      S_DATA:  if (w_cnt_zero && (r_bit_idx == 3'd7)) w_next = S_STOP;
      S_STOP:  if (w_cnt_zero) w_next = r_rx_s ? S_IDLE : S_BREAK;
      S_BREAK: if (r_rx_s) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // FSM outputs: busy level, push strobe and framing-error pulse
  always_comb begin
    busy      = (r_state != S_IDLE);
    w_push    = 1'b0;
    frame_err = 1'b0;
    if (r_state == S_STOP && w_cnt_zero) begin
      w_push    = r_rx_s;
      frame_err = !r_rx_s;
    end
  end

  // Bit timer, bit index and LSB-first shift register
  always_ff @(posedge clk12 or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= 16'd0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!r_rx_s) r_cnt <= C_HALF_RELOAD;
        end
        S_START: begin
          if (!w_cnt_zero) begin
            r_cnt <= r_cnt - 16'd1;
          end else if (!r_rx_s) begin
            r_cnt     <= C_BIT_RELOAD;
            r_bit_idx <= 3'd0;
          end
        end
        S_DATA: begin
          if (!w_cnt_zero) begin
            r_cnt <= r_cnt - 16'd1;
          end else begin
            r_shift   <= {r_rx_s, r_shift[7:1]};
            r_cnt     <= C_BIT_RELOAD;
            r_bit_idx <= r_bit_idx + 3'd1;
          end
        end
        S_STOP: begin
          if (!w_cnt_zero) r_cnt <= r_cnt - 16'd1;
        end
        default: r_cnt <= 16'd0;
      endcase
    end
  end

  // FIFO control: a pop in the same cycle frees a slot for a push into a full FIFO
  assign w_full    = (r_level == LW'(FIFO_DEPTH));
  assign out_valid = (r_level != '0);
  assign w_pop     = out_valid & out_ready;
  assign w_accept  = w_push & (~w_full | w_pop);
  assign overrun   = w_push & w_full & ~w_pop;
  assign out_data  = out_valid ? r_mem[r_rd_ptr] : 8'h00;
  assign fifo_level = r_level;

  // FIFO pointers and occupancy; full/empty come from the level only
  always_ff @(posedge clk12 or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_accept) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)    r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_accept && !w_pop) begin
        r_level <= r_level + LW'(1);
      end else if (!w_accept && w_pop) begin
        r_level <= r_level - LW'(1);
      end
    end
  end

  // FIFO storage; contents are don't-care until written
  always_ff @(posedge clk12) begin
    if (w_accept) r_mem[r_wr_ptr] <= r_shift;
  end

endmodule

// File: doc/uart_tx_capture.md
Name: uart_tx_capture

Overview:
- Simulation-side receiver for the SoC's serial_tx output.
- Consumes the console UART stream and oversamples it on the main 12 MHz clock.
- Decodes 8N1 frames and buffers decoded bytes in a small show-ahead FIFO.
- Bench logic and CI report logic drain the FIFO through a valid/ready interface, and framing/overrun events are flagged.

Parameters:
- CLKS_PER_BIT, 104, clk12 cycles per UART bit (12 MHz / 115200 ≈ 104); legal range 8..65535.
- FIFO_DEPTH, 16, decoded-byte buffer depth; power of two, 2..256.

Ports:
- clk12  input  1  main clock; all logic is on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- rx  input  1  serial line from DUT serial_tx; idle high.
- out_data  output  8  byte at FIFO head.
- out_valid  output  1  FIFO not empty.
- out_ready  input  1  consumer accepts out_data when out_valid & out_ready.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: byte dropped because the FIFO was full.
- fifo_level  output  $clog2(FIFO_DEPTH+1)  bytes currently held.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset:
  - Clock and reset are fixed: single clock clk12; rst_n is asynchronous, active-low.
  - While reset is asserted, the sync flops are set to 1, FSM=IDLE, counters=0, FIFO empty.
  - Output reset values: out_valid=0, out_data=0, frame_err=0, overrun=0, fifo_level=0, busy=0.
- Input sync: rx passes through a 2-flop synchronizer (rx_s); all decoding uses rx_s. Edge-to-decision latency is therefore +2 cycles.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE: rx_s==0 → START, with the bit counter loaded to CLKS_PER_BIT/2 - 1 (floor).
- START: counts down to 0, then samples rx_s.
  - 1 → IDLE (glitch rejected; nothing is pushed and no flag is raised).
  - 0 → DATA, with the counter reloaded to CLKS_PER_BIT-1 and bit index = 0.
- DATA: samples rx_s each time the counter reaches 0.
  - Bits are shifted in LSB first and the counter is reloaded.
  - After bit 7 is sampled → STOP.
- STOP: samples at counter 0.
  - 1 → the byte is pushed to the FIFO, then → IDLE.
  - 0 → frame_err pulses for one cycle, the byte is discarded, then → BREAK.
- BREAK: waits until rx_s==1, then → IDLE. A line held low never produces bytes.
- Sample timing: every sample is taken mid-bit, at 1.5, 2.5, … 9.5 bit times after the synced falling edge.
- Push timing: out_valid rises the cycle after the stop-bit sample when the FIFO was empty.
- FIFO organisation: show-ahead; out_data always presents the head entry. Pop happens on out_valid & out_ready.
- Push into a full FIFO: the byte is dropped and overrun pulses for one cycle; FIFO contents are unchanged.
- Simultaneous push and pop:
  - When full: the pop frees a slot, the push is accepted, overrun=0, and the level is unchanged.
  - When empty: there is no pop because out_valid=0; the push is accepted and the level becomes 1.
- fifo_level: increments and decrements in the same cycle as the push/pop; it never exceeds FIFO_DEPTH.
- Pointers: wrap modulo FIFO_DEPTH. Full/empty is derived from the level, not from pointer equality.
- Reset mid-frame: the partial byte is abandoned, the FIFO is flushed, and no flags fire on reset release.
- Back-to-back frames: a start edge arriving immediately after the stop sample (rx_s low in IDLE) is accepted with no idle gap required.

Test Plan:
- Byte 0x55 sent at 104 cycles/bit → exactly one entry; out_data=0x55. out_valid rises 2+1.5·104+8·104+1 cycles (±1) after the rx falling edge; fifo_level=1, and 0 after the pop.
- String "OK\n" (0x4F,0x4B,0x0A) sent back-to-back, out_ready=1 → three pops in order; frame_err=0 and overrun=0 throughout.
- rx low pulse of 20 cycles → no push, busy returns low by about cycle 55. A following 0x3C decodes correctly.
- 0xA5 with stop bit forced 0, then rx held low 2000 cycles:
  - frame_err pulses exactly once and fifo_level stays 0.
  - After rx goes high, 0x3C decodes.
- out_ready=0 while sending 17 bytes 0x00..0x10 (FIFO_DEPTH=16):
  - Level saturates at 16 and overrun pulses once, on the 17th byte.
  - Draining yields 0x00..0x0F.
  - Separate case: full FIFO with a pop coinciding with a push → push accepted, no overrun.
- rst_n asserted asynchronously during DATA bit 4 of a byte, FIFO holding 3 bytes:
  - Outputs go to reset values immediately.
  - After release, the next 0x81 is the only byte received.
